// File: rtl/rca_multiword_seq.sv
`default_nettype none
// ============================================================================
// Module   : rca_multiword_seq
// Purpose  : W-bit (N*WORDS) add performed LSB-first over WORDS cycles on a
//            single N-bit ripple-carry adder, with valid/ready handshakes.
//            Optional macro RCA_SEQ_SUB_EN adds a 'sub' port (a - b).
// Revision : 1.0 - initial release
// ============================================================================

module rca_nbit #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] s,
    output logic         c_out
);
    logic [N:0] w_c;

    assign w_c[0] = c_in;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign s[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign c_out = w_c[N];
endmodule

module rca_multiword_seq #(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    input  logic               c_in,
`ifdef RCA_SEQ_SUB_EN
    input  logic               sub,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WORDS-1:0] s,
    output logic               c_out,
    output logic               busy
);
    localparam int W     = N * WORDS;
    localparam int IDX_W = $clog2(WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(WORDS - 1);
    localparam logic [IDX_W-1:0] C_ONE  = IDX_W'(1);

    logic [1:0]       r_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     r_s;
    logic             r_c_out;

    logic [N-1:0]     w_sum;
    logic             w_cout;
    logic [W-1:0]     w_b_in;
    logic             w_c_in;

    // Operands are shifted right each slice, so the adder always sees bits [N-1:0].
    rca_nbit #(.N(N)) u_rca (
        .a     (r_a[N-1:0]),
        .b     (r_b[N-1:0]),
        .c_in  (r_carry),
        .s     (w_sum),
        .c_out (w_cout)
    );

`ifdef RCA_SEQ_SUB_EN
    // Subtraction as a + ~b + 1; the forced carry-in replaces c_in.
    assign w_b_in = sub ? ~b : b;
    assign w_c_in = sub | c_in;
`else
    assign w_b_in = b;
    assign w_c_in = c_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_s     <= '0;
            r_c_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= w_b_in;
                        r_carry <= w_c_in;
                        r_idx   <= '0;
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_s[r_idx*N +: N] <= w_sum;
                    r_carry           <= w_cout;
                    r_a               <= r_a >> N;
                    r_b               <= r_b >> N;
                    r_idx             <= r_idx + C_ONE;
                    if (r_idx == C_LAST) begin
                        r_c_out <= w_cout;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_ADD) || (r_state == S_DONE);
    assign s         = r_s;
    assign c_out     = r_c_out;

endmodule
`default_nettype wire

// File: tb/tb_rca_multiword_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_rca_multiword_seq
// Purpose  : Self-checking bench for rca_multiword_seq against an integer
//            reference model ({c_out,s} = a + b + c_in, or a - b).
// Revision : 1.0 - initial release
// ============================================================================

module tb_rca_multiword_seq;
    localparam int N     = 4;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
`ifdef RCA_SEQ_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         c_out;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int n_hs     = 0;

    rca_multiword_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef RCA_SEQ_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c_out     (c_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake monitor: one result handshake is owed per accepted operand set.
    always @(posedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready)   n_acc++;
            if (out_valid && out_ready) n_hs++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge back in IDLE.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input logic tsub, input int hold);
        int           lat;
        logic [W:0]   exp_r;
        logic [W-1:0] nb;
        logic [W-1:0] s_hold;
        logic         c_hold;
        nb = ~tb_v;
        if (tsub) exp_r = {1'b0, ta} + {1'b0, nb} + (W+1)'(1);
        else      exp_r = {1'b0, ta} + {1'b0, tb_v} + (W+1)'(tc);

        check_val("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        a        = ta;
        b        = tb_v;
        c_in     = tc;
`ifdef RCA_SEQ_SUB_EN
        sub      = tsub;
`endif
        @(negedge clk);
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        c_in     = 1'($urandom);
`ifdef RCA_SEQ_SUB_EN
        sub      = 1'($urandom);
`endif
        lat = 0;
        while (!out_valid && lat < 40) begin
            check_val("in_ready_busy", 64'(in_ready), 64'd0);
            out_ready = 1'($urandom);
            in_valid  = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_val("latency", 64'(lat), 64'(WORDS));
        check_val("result", 64'({c_out, s}), 64'(exp_r));
        s_hold = s;
        c_hold = c_out;
        repeat (hold) begin
            in_valid = 1'b1;
            a        = W'($urandom);
            @(negedge clk);
            check_val("hold_s", 64'(s), 64'(s_hold));
            check_val("hold_cout", 64'(c_out), 64'(c_hold));
            check_val("hold_valid", 64'(out_valid), 64'd1);
            check_val("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val("post_valid", 64'(out_valid), 64'd0);
        check_val("post_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        a         = 16'hAAAA;
        b         = 16'h5555;
        c_in      = 1'b1;
`ifdef RCA_SEQ_SUB_EN
        sub       = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_s", 64'(s), 64'd0);
        check_val("rst_cout", 64'(c_out), 64'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check_val("rel_busy", 64'(busy), 64'd0);

        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 5);
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);

        // Abort an op partway through with an asynchronous reset.
        in_valid = 1'b1;
        a        = 16'hFFFF;
        b        = 16'h1111;
        c_in     = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("abort_in_ready", 64'(in_ready), 64'd1);
        check_val("abort_busy", 64'(busy), 64'd0);
        check_val("abort_s", 64'(s), 64'd0);
        check_val("abort_cout", 64'(c_out), 64'd0);
        repeat (2) begin
            @(negedge clk);
            check_val("abort_valid", 64'(out_valid), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_val("abort_valid_rel", 64'(out_valid), 64'd0);
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1);

`ifdef RCA_SEQ_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 0);
`endif

        for (int k = 0; k < 200; k++) begin
            logic tsub;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            tsub = 1'b0;
`ifdef RCA_SEQ_SUB_EN
            tsub = 1'($urandom);
`endif
            run_op(W'($urandom), W'($urandom), 1'($urandom), tsub, $urandom_range(0, 3));
        end

        @(negedge clk);
        check_val("handshakes", 64'(n_hs), 64'(n_acc - 1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
